// File: rtl/ms_slave_regfile.sv
// Parametrised register-file slave: N registers with byte-lane writes, registered reads,
// a range of slow registers that insert wait states, and out-of-range error pulses.
module ms_slave_regfile #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 8,
    parameter int SLOW_BASE   = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid,
    input  logic                         wr,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            data,
    input  logic [DATA_W/8-1:0]          wstrb,
    output logic                         sready,
    output logic [DATA_W-1:0]            rdata,
    output logic                         rvalid,
    output logic                         err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam bit HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic [31:0]        addr_ext;
    logic [IDX_W-1:0]   idx;
    logic               in_range;
    logic               is_slow;
    logic               fire;

    assign addr_ext = 32'(addr);
    assign idx      = IDX_W'(addr);
    assign in_range = (addr_ext < 32'(NUM_REGS));
    // Out-of-range addresses are never slow, so they always complete in IDLE.
    assign is_slow  = HAS_WAIT && in_range && (addr_ext >= 32'(SLOW_BASE));

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sready = 1'b1;
        case (state)
            S_IDLE: sready = !(valid && is_slow);
            S_WAIT: sready = (cnt == '0);
            default: sready = 1'b1;
        endcase
    end

    assign fire = valid && sready;

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid && is_slow) begin
                        cnt   <= CNT_LOAD;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Dropping valid mid-wait abandons the access; completion happens via fire.
                    if (!valid || cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the register array is reset because downstream logic consumes regs_o directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= fire && !wr;
            err    <= fire && !in_range;
            if (fire && !wr) begin
                rdata <= in_range ? regs[idx] : '0;
            end
            if (fire && wr && in_range) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (wstrb[b]) begin
                        regs[idx][b*8 +: 8] <= data[b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
        assign regs_o[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule
